// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter with open-drain pin enables and a bus watchdog.
// Define PS2_TX_RETRY_EN to retry a failed frame automatically (up to 2 retries).
module ps2_host_tx #(
  parameter int unsigned INHIBIT_CYCLES = 12000,
  parameter int unsigned TIMEOUT_CYCLES = 1500000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       rx_inhibit,
  output logic       done,
  output logic       ack_err,
  output logic       timeout_err
);

  typedef enum logic [2:0] {
    StIdle, StInhibit, StStart, StData, StStop, StAck, StWaitIdle
  } state_e;

  state_e      state_q, state_d;
  logic [8:0]  shreg_q, shreg_d;
  logic        bit_q, bit_d;
  logic [3:0]  bitcnt_q, bitcnt_d;
  logic [20:0] cnt_q, cnt_d;
  logic        ack_bad_q, ack_bad_d;
  logic        done_q, done_d;
  logic        ack_err_q, ack_err_d;
  logic        timeout_err_q, timeout_err_d;
  logic [2:0]  clk_sync_q;
  logic [1:0]  data_sync_q;
`ifdef PS2_TX_RETRY_EN
  logic [1:0]  retry_q, retry_d;
`endif

  logic sync_clk, sync_data, fall, inhibit_last, expire_ev, fail_ack, fail_to;

  assign sync_clk     = clk_sync_q[1];
  assign sync_data    = data_sync_q[1];
  assign fall         = clk_sync_q[2] & ~clk_sync_q[1];
  assign inhibit_last = (cnt_q == 21'(INHIBIT_CYCLES - 1));
  // A fall on the expiry cycle wins over the timeout.
  assign expire_ev    = ~fall & (cnt_q == 21'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_d       = state_q;
    shreg_d       = shreg_q;
    bit_d         = bit_q;
    bitcnt_d      = bitcnt_q;
    cnt_d         = cnt_q;
    ack_bad_d     = ack_bad_q;
    done_d        = 1'b0;
    ack_err_d     = 1'b0;
    timeout_err_d = 1'b0;
    fail_ack      = 1'b0;
    fail_to       = 1'b0;
`ifdef PS2_TX_RETRY_EN
    retry_d       = retry_q;
`endif
    if (state_q != StIdle && state_q != StInhibit) begin
      cnt_d = fall ? '0 : cnt_q + 21'd1;
    end
    case (state_q)
      StIdle: begin
        if (tx_valid) begin
          shreg_d = {~^tx_data, tx_data};
          cnt_d   = '0;
          state_d = StInhibit;
`ifdef PS2_TX_RETRY_EN
          retry_d = 2'd0;
`endif
        end
      end
      StInhibit: begin
        if (inhibit_last) begin
          cnt_d   = '0;
          state_d = StStart;
        end else begin
          cnt_d = cnt_q + 21'd1;
        end
      end
      StStart: begin
        if (fall) begin
          bit_d    = shreg_q[0];
          bitcnt_d = 4'd1;
          state_d  = StData;
        end else if (expire_ev) begin
          fail_to = 1'b1;
        end
      end
      StData: begin
        if (fall) begin
          bit_d = shreg_q[bitcnt_q];
          if (bitcnt_q == 4'd8) begin
            state_d = StStop;
          end else begin
            bitcnt_d = bitcnt_q + 4'd1;
          end
        end else if (expire_ev) begin
          fail_to = 1'b1;
        end
      end
      StStop: begin
        if (fall) begin
          state_d = StAck;
        end else if (expire_ev) begin
          fail_to = 1'b1;
        end
      end
      StAck: begin
        if (fall) begin
          ack_bad_d = sync_data;
          state_d   = StWaitIdle;
        end else if (expire_ev) begin
          fail_to = 1'b1;
        end
      end
      StWaitIdle: begin
        if (sync_clk && sync_data) begin
          if (ack_bad_q) begin
            fail_ack = 1'b1;
          end else begin
            done_d  = 1'b1;
            state_d = StIdle;
          end
        end else if (expire_ev) begin
          fail_to = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
    if (fail_ack || fail_to) begin
`ifdef PS2_TX_RETRY_EN
      if (retry_q != 2'd2) begin
        retry_d = retry_q + 2'd1;
        cnt_d   = '0;
        state_d = StInhibit;
      end else begin
        state_d       = StIdle;
        ack_err_d     = fail_ack;
        timeout_err_d = fail_to;
      end
`else
      state_d       = StIdle;
      ack_err_d     = fail_ack;
      timeout_err_d = fail_to;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= StIdle;
      shreg_q       <= '0;
      bit_q         <= 1'b1;
      bitcnt_q      <= '0;
      cnt_q         <= '0;
      ack_bad_q     <= 1'b0;
      done_q        <= 1'b0;
      ack_err_q     <= 1'b0;
      timeout_err_q <= 1'b0;
      clk_sync_q    <= 3'b111;
      data_sync_q   <= 2'b11;
`ifdef PS2_TX_RETRY_EN
      retry_q       <= 2'd0;
`endif
    end else begin
      state_q       <= state_d;
      shreg_q       <= shreg_d;
      bit_q         <= bit_d;
      bitcnt_q      <= bitcnt_d;
      cnt_q         <= cnt_d;
      ack_bad_q     <= ack_bad_d;
      done_q        <= done_d;
      ack_err_q     <= ack_err_d;
      timeout_err_q <= timeout_err_d;
      clk_sync_q    <= {clk_sync_q[1:0], ps2_clk_i};
      data_sync_q   <= {data_sync_q[0], ps2_data_i};
`ifdef PS2_TX_RETRY_EN
      retry_q       <= retry_d;
`endif
    end
  end

  // Enables decode straight from reset-cleared state so reset releases the pins at once.
  assign ps2_clk_oe  = (state_q == StInhibit);
  assign ps2_data_oe = (state_q == StInhibit && inhibit_last) || (state_q == StStart) ||
                       ((state_q == StData || state_q == StStop) && !bit_q);
  assign tx_ready    = (state_q == StIdle);
  assign busy        = (state_q != StIdle);
  assign rx_inhibit  = busy;
  assign done        = done_q;
  assign ack_err     = ack_err_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Self-checking bench for ps2_host_tx with an open-drain PS/2 device model and a byte scoreboard.
module tb_ps2_host_tx;
  localparam int INH = 10;
  localparam int TMO = 200;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, ps2_clk_oe, ps2_data_oe, busy, rx_inhibit, done, ack_err, timeout_err;
  logic       dev_clk_low = 1'b0;
  logic       dev_data_low = 1'b0;
  logic       ps2_clk_line, ps2_data_line;

  int n_tests = 0;
  int n_fail = 0;
  int done_cnt = 0;
  int aerr_cnt = 0;
  int terr_cnt = 0;
  int clkoe_cnt = 0;
  logic [7:0] sb[$];

  assign ps2_clk_line  = ~(ps2_clk_oe | dev_clk_low);
  assign ps2_data_line = ~(ps2_data_oe | dev_data_low);

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .ps2_clk_i(ps2_clk_line), .ps2_data_i(ps2_data_line), .ps2_clk_oe(ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe), .busy(busy), .rx_inhibit(rx_inhibit), .done(done),
    .ack_err(ack_err), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (done) done_cnt++;
    if (ack_err) aerr_cnt++;
    if (timeout_err) terr_cnt++;
    if (ps2_clk_oe) clkoe_cnt++;
  end

  // Expected bytes enter the scoreboard at the accept handshake.
  always @(posedge clk) if (rst && tx_valid && tx_ready) sb.push_back(tx_data);

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation exceeded 50000 cycles");
    $fatal(1);
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    tx_data  = b;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic wait_start(input string tag, output logic ok);
    int t = 0;
    while (!(busy && ps2_clk_line && !ps2_data_line) && t < 3000) begin
      @(negedge clk);
      t++;
    end
    ok = (t < 3000);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s_start: no start bit after %0d cycles, required within 3000", tag, t);
    end
  endtask

  task automatic dev_pulse(output logic sampled);
    dev_clk_low = 1'b1;
    cyc(20);
    sampled = ps2_data_line;
    dev_clk_low = 1'b0;
    cyc(20);
  endtask

  // Device clocks 11 pulses, reads bits before each rising edge, ACKs (or not) on pulse 11.
  task automatic device_frame(input logic nack, input string tag);
    logic [10:0] bits;
    logic [7:0]  exp;
    logic        ok;
    wait_start(tag, ok);
    if (!ok) return;
    cyc(15);
    for (int i = 0; i < 10; i++) dev_pulse(bits[i]);
    cyc(5);
    dev_data_low = ~nack;
    cyc(15);
    dev_pulse(bits[10]);
    dev_data_low = 1'b0;
    exp = (sb.size() > 0) ? sb[0] : 8'hxx;
    n_tests++;
    if ({bits[9], bits[8], bits[7:0]} !== {1'b1, ~^exp, exp}) begin
      n_fail++;
      $display("FAIL %s_frame: got stop=%b par=%b data=%h, required stop=1 par=%b data=%h",
               tag, bits[9], bits[8], bits[7:0], ~^exp, exp);
    end
  endtask

  task automatic test_reset;
    rst = 1'b0;
    cyc(3);
    n_tests++;
    if ({ps2_clk_oe, ps2_data_oe, busy, rx_inhibit, tx_ready, done, ack_err, timeout_err}
        !== 8'b0000_1000) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b, required 00001000",
               {ps2_clk_oe, ps2_data_oe, busy, rx_inhibit, tx_ready, done, ack_err, timeout_err});
    end
    rst = 1'b1;
    cyc(3);
  endtask

  task automatic test_frame(input logic [7:0] b, input string tag);
    int d0 = done_cnt, a0 = aerr_cnt, t0 = terr_cnt, c0 = clkoe_cnt;
    send(b);
    device_frame(1'b0, tag);
    cyc(10);
    n_tests++;
    if (clkoe_cnt - c0 != INH) begin
      n_fail++;
      $display("FAIL %s_inhibit: clk_oe high %0d cycles, required %0d", tag, clkoe_cnt - c0, INH);
    end
    n_tests++;
    if ({done_cnt - d0, aerr_cnt - a0, terr_cnt - t0} !== {32'd1, 32'd0, 32'd0}) begin
      n_fail++;
      $display("FAIL %s_pulses: done=%0d ack_err=%0d timeout_err=%0d, required 1/0/0",
               tag, done_cnt - d0, aerr_cnt - a0, terr_cnt - t0);
    end
    n_tests++;
    if ({tx_ready, ps2_clk_oe, ps2_data_oe} !== 3'b100) begin
      n_fail++;
      $display("FAIL %s_idle: ready/clk_oe/data_oe=%b, required 100",
               tag, {tx_ready, ps2_clk_oe, ps2_data_oe});
    end
    if (sb.size() > 0) void'(sb.pop_front());
  endtask

  task automatic test_ack_err;
    int d0 = done_cnt, a0 = aerr_cnt, t0 = terr_cnt, c0 = clkoe_cnt;
    int attempts;
`ifdef PS2_TX_RETRY_EN
    attempts = 3;
`else
    attempts = 1;
`endif
    send(8'hFF);
    for (int a = 0; a < attempts; a++) device_frame(1'b1, "ackerr");
    cyc(10);
    n_tests++;
    if ({done_cnt - d0, aerr_cnt - a0, terr_cnt - t0} !== {32'd0, 32'd1, 32'd0}) begin
      n_fail++;
      $display("FAIL ackerr_pulses: done=%0d ack_err=%0d timeout_err=%0d, required 0/1/0",
               done_cnt - d0, aerr_cnt - a0, terr_cnt - t0);
    end
    n_tests++;
    if (clkoe_cnt - c0 != INH * attempts || tx_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL ackerr_attempts: clk_oe cycles=%0d ready=%b, required %0d and 1",
               clkoe_cnt - c0, tx_ready, INH * attempts);
    end
    if (sb.size() > 0) void'(sb.pop_front());
  endtask

  task automatic test_timeout;
    int d0 = done_cnt, a0 = aerr_cnt, t0 = terr_cnt;
    int attempts, t, n;
`ifdef PS2_TX_RETRY_EN
    attempts = 3;
`else
    attempts = 1;
`endif
    send(8'hF4);
    for (int a = 0; a < attempts; a++) begin
      t = 0;
      while (!ps2_clk_oe && t < 100) begin @(negedge clk); t++; end
      while (ps2_clk_oe && t < 200) begin @(negedge clk); t++; end
      n = 0;
      while (!timeout_err && !ps2_clk_oe && n < 400) begin @(negedge clk); n++; end
      n_tests++;
      if (n != TMO || t >= 200) begin
        n_fail++;
        $display("FAIL timeout_latency: event after %0d cycles in START, required %0d", n, TMO);
      end
      n_tests++;
      if (a == attempts - 1) begin
        if ({timeout_err, ps2_clk_oe, ps2_data_oe, tx_ready} !== 4'b1001) begin
          n_fail++;
          $display("FAIL timeout_final: terr/clk_oe/data_oe/ready=%b, required 1001",
                   {timeout_err, ps2_clk_oe, ps2_data_oe, tx_ready});
        end
      end else if ({timeout_err, ps2_clk_oe, busy} !== 3'b011) begin
        n_fail++;
        $display("FAIL timeout_retry: terr/clk_oe/busy=%b, required 011",
                 {timeout_err, ps2_clk_oe, busy});
      end
    end
    cyc(5);
    n_tests++;
    if ({done_cnt - d0, aerr_cnt - a0, terr_cnt - t0} !== {32'd0, 32'd0, 32'd1}) begin
      n_fail++;
      $display("FAIL timeout_pulses: done=%0d ack_err=%0d timeout_err=%0d, required 0/0/1",
               done_cnt - d0, aerr_cnt - a0, terr_cnt - t0);
    end
    if (sb.size() > 0) void'(sb.pop_front());
  endtask

  task automatic test_reset_mid;
    int d0 = done_cnt, a0 = aerr_cnt, t0 = terr_cnt;
    logic ok, s;
    send(8'hA5);
    wait_start("rstmid", ok);
    cyc(15);
    for (int i = 0; i < 4; i++) dev_pulse(s);
    dev_clk_low = 1'b1;
    cyc(10);
    n_tests++;
    if ({busy, ps2_data_oe} !== 2'b11) begin
      n_fail++;
      $display("FAIL rstmid_bit4: busy/data_oe=%b, required 11 (bit4 of A5 is 0)",
               {busy, ps2_data_oe});
    end
    #2 rst = 1'b0;
    #1;
    n_tests++;
    if ({ps2_clk_oe, ps2_data_oe, tx_ready, busy} !== 4'b0010) begin
      n_fail++;
      $display("FAIL rstmid_async: clk_oe/data_oe/ready/busy=%b, required 0010",
               {ps2_clk_oe, ps2_data_oe, tx_ready, busy});
    end
    dev_clk_low = 1'b0;
    cyc(3);
    rst = 1'b1;
    cyc(300);
    n_tests++;
    if ({done_cnt - d0, aerr_cnt - a0, terr_cnt - t0} !== {32'd0, 32'd0, 32'd0} ||
        tx_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rstmid_quiet: done=%0d ack_err=%0d terr=%0d ready=%b, required 0/0/0/1",
               done_cnt - d0, aerr_cnt - a0, terr_cnt - t0, tx_ready);
    end
    if (sb.size() > 0) void'(sb.pop_front());
  endtask

  task automatic test_back_to_back;
    int d0 = done_cnt;
    int t = 0;
    @(negedge clk);
    tx_data  = 8'h3C;
    tx_valid = 1'b1;
    fork
      device_frame(1'b0, "b2b1");
      begin cyc(100); tx_data = 8'h96; end
    join
    while (!done && t < 40) begin @(negedge clk); t++; end
    n_tests++;
    if (done !== 1'b1 || tx_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_done: done=%b ready=%b, required 1 and 1", done, tx_ready);
    end
    @(negedge clk);
    tx_valid = 1'b0;
    n_tests++;
    if (busy !== 1'b1 || sb.size() != 2) begin
      n_fail++;
      $display("FAIL b2b_accept: busy=%b accepted=%0d, required 1 and 2", busy, sb.size());
    end
    if (sb.size() > 0) void'(sb.pop_front());
    device_frame(1'b0, "b2b2");
    cyc(10);
    if (sb.size() > 0) void'(sb.pop_front());
    n_tests++;
    if (done_cnt - d0 != 2 || sb.size() != 0) begin
      n_fail++;
      $display("FAIL b2b_end: done=%0d leftover=%0d, required 2 and 0", done_cnt - d0, sb.size());
    end
  endtask

  initial begin
    test_reset;
    test_frame(8'hED, "ed");
    test_frame(8'hF4, "f4");
    test_frame(8'h00, "zero");
    test_ack_err;
    test_timeout;
    test_reset_mid;
    test_back_to_back;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
